// File: rtl/seq_word_comparator.sv
// Sequential W-bit unsigned comparator built around an external 3-bit cascade
// comparator; slices are presented LSB first so higher slices override lower ones.
module seq_word_comparator #(
    parameter int SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3*SLICES-1:0]   a,
    input  logic [3*SLICES-1:0]   b,
    output logic [2:0]            slice_a,
    output logic [2:0]            slice_b,
    output logic                  cas_l,
    output logic                  cas_e,
    output logic                  cas_g,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt,
    output logic                  busy,
    output logic                  done,
    output logic                  lt,
    output logic                  eq,
    output logic                  gt,
    output logic                  err
);

    localparam int W  = 3 * SLICES;
    localparam int IW = $clog2(SLICES);
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IW-1:0]   idx;
    logic [2:0]      cas;
    logic [2:0]      cmp;
    logic            cmp_bad;

    assign cmp = {cmp_lt, cmp_eq, cmp_gt};
    // For three bits: one-hot exactly when parity is odd and not all bits set.
    assign cmp_bad = ~(^cmp) | (&cmp);

    always_comb begin
        slice_a = 3'b000;
        slice_b = 3'b000;
        {cas_l, cas_e, cas_g} = 3'b010;
        if (state == RUN) begin
            slice_a = a_reg[3*idx +: 3];
            slice_b = b_reg[3*idx +: 3];
            {cas_l, cas_e, cas_g} = cas;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            cas   <= 3'b010;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        idx   <= '0;
                        cas   <= 3'b010;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cas <= cmp;
                    if (cmp_bad) err <= 1'b1;
                    if (idx == LAST) begin
                        {lt, eq, gt} <= cmp;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_word_comparator.md
SEQ_WORD_COMPARATOR -- requirements
Module: seq_word_comparator

Interface
REQ-001 The block SHALL have parameter SLICES, default 4, giving the number of 3-bit slices; operand width W = 3*SLICES; legal range is 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to compare; sampled on the rising edge of clk.
REQ-005 a  input  W  operand A; sampled only when start is accepted.
REQ-006 b  input  W  operand B; sampled only when start is accepted.
REQ-007 slice_a  output  3  current A slice, driven to the external comparator_3_bit a input.
REQ-008 slice_b  output  3  current B slice, driven to the comparator_3_bit b input.
REQ-009 cas_l, cas_e, cas_g  output  1 each  cascade state, driven to the comparator_3_bit l, e and g inputs.
REQ-010 cmp_lt, cmp_eq, cmp_gt  input  1 each  combinational result returned by comparator_3_bit in the same cycle.
REQ-011 busy  output  1  high while a comparison is in progress.
REQ-012 done  output  1  single-cycle pulse when the result is valid.
REQ-013 lt, eq, gt  output  1 each  registered final result for A versus B, unsigned.
REQ-014 err  output  1  sticky flag; set when the comparator returns a result that is not one-hot.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE: start=1 SHALL latch a and b into internal registers, clear the slice index idx to 0, load the cascade state (l,e,g)=(0,1,0), and move to RUN.
REQ-017 RUN: slice_a SHALL equal a_reg[3*idx+2 : 3*idx] and slice_b SHALL equal b_reg[3*idx+2 : 3*idx]; this processes LSB slice first, because the cascade carries lower-significance results upward.
REQ-018 RUN: cas_l, cas_e and cas_g SHALL be driven directly from the cascade state registers.
REQ-019 RUN: on each edge, the cascade state SHALL load {cmp_lt, cmp_eq, cmp_gt} and idx SHALL increment.
REQ-020 RUN: when idx = SLICES-1, the edge SHALL also load lt, eq and gt from cmp_lt, cmp_eq and cmp_gt, and move to DONE.
REQ-021 DONE: done=1 for exactly one cycle; the next state SHALL be RUN if start=1 (with a new latch and init as in REQ-016), otherwise IDLE.
REQ-022 busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-023 Latency: with start accepted at edge 0, done SHALL be high in the cycle after edge SLICES (5 cycles for SLICES=4).
REQ-024 start while in RUN SHALL be ignored; the operands in flight SHALL remain unchanged.
REQ-025 Changes on a and b after acceptance SHALL NOT affect the result.
REQ-026 lt, eq and gt SHALL hold their value from DONE until the next result is loaded; they SHALL NOT clear on a new start.
REQ-027 In IDLE and DONE: slice_a=0, slice_b=0, (cas_l,cas_e,cas_g)=(0,1,0).
REQ-028 In RUN, if {cmp_lt, cmp_eq, cmp_gt} is not exactly one-hot, err SHALL set on that edge and stay set until reset; the sequence SHALL still complete normally.
REQ-029 idx SHALL be ceil(log2(SLICES)) bits wide and SHALL never exceed SLICES-1.

Reset
REQ-030 When rst=1, the block SHALL immediately reset, independent of clk: state=IDLE, idx=0, cascade state=(0,1,0), lt=0, eq=0, gt=0, done=0, busy=0, err=0.
REQ-031 rst asserted during RUN SHALL abort the comparison; no done pulse SHALL follow.
REQ-032 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-033 The bench SHALL connect the block to a real comparator_3_bit and use SLICES=4 for all directed cases below.
REQ-034 a=12'h123, b=12'h123, start pulse -> done 5 cycles later; eq=1, lt=0, gt=0; err=0.
REQ-035 a=12'h800, b=12'h7FF -> gt=1; the slice sequence seen on slice_a/slice_b is 0/7, 0/7, 0/7, 4/3.
REQ-036 a=12'h001, b=12'h002 -> lt=1 (LSB slice decides, upper slices equal); then a=12'h202, b=12'h101 started in the DONE cycle -> gt=1 after a further 4 edges.
REQ-037 Reset abort: start with a=12'hFFF, b=12'h000; assert rst after 2 edges -> all outputs 0 at once, no done; a new start then gives gt=1.
REQ-038 start held high through RUN, with a and b changed mid-run -> the original result is reported; a forced cmp {1,1,0} during RUN -> err=1, and it stays 1 after done.
